ddr_burst_arbiter: RTL and testbench
====================================

Name: ddr_burst_arbiter

Overview:
- Shares the single DDR3 burst port between NUM_REQ requesters, e.g. ROM loader, ROM reader and frame buffer writer.
- Sits between the requester blocks and the top-level DDRAM_* pins.
- Grants one whole burst at a time, round-robin, and forwards each handshake to its owner.
- Routes read beats back to the granted requester and counts beats to detect the end of each burst.

Parameters:
- NUM_REQ, 3: number of requester ports (2..8).
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 64: beat width.
- BURST_WIDTH, 8: burst-length width.

Ports:
- clock  in  1  system clock, all logic.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  NUM_REQ  per-requester read request.
- req_wr  in  NUM_REQ  per-requester write request/beat.
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst start address, slice i = requester i.
- req_burst  in  NUM_REQ*BURST_WIDTH  burst length in beats.
- req_din  in  NUM_REQ*DATA_WIDTH  write beat data.
- req_mask  in  NUM_REQ*DATA_WIDTH/8  write byte enables.
- req_wait_req  out  NUM_REQ  1 = command/beat not accepted, hold it.
- req_valid  out  NUM_REQ  read beat valid for requester i.
- req_dout  out  DATA_WIDTH  read beat data, shared by all requesters.
- req_burst_done  out  NUM_REQ  1-cycle pulse after the last beat of requester i's burst.
- ddr_rd  out  1  read command to DDR.
- ddr_wr  out  1  write beat to DDR.
- ddr_addr  out  ADDR_WIDTH  DDR address.
- ddr_burst_length  out  BURST_WIDTH  DDR burst count.
- ddr_mask  out  DATA_WIDTH/8  DDR byte enables.
- ddr_din  out  DATA_WIDTH  DDR write data.
- ddr_dout  in  DATA_WIDTH  DDR read data.
- ddr_wait_req  in  1  DDR busy.
- ddr_valid  in  1  DDR read data valid.

Behaviour:
- Reset values: state IDLE, ddr_rd=0, ddr_wr=0, ddr_addr=0, ddr_burst_length=0, req_wait_req=all 1, req_valid=0, req_burst_done=0, grant=0, rr pointer=0, beat counter=0.
- States: IDLE, READ_CMD, READ_DATA, WRITE.
- IDLE:
  - Each requester's pending flag = req_rd[i]|req_wr[i].
  - Pick the first pending index at or after rr pointer, wrapping modulo NUM_REQ.
  - Register grant index and that requester's burst length; burst length 0 is treated as 1.
  - Next state is READ_CMD if req_rd[grant], else WRITE. If both rd and wr are set, read wins and the write stays pending.
  - Stay in IDLE when nothing is pending. ddr_valid is ignored in IDLE.
- Grant latency: a request first seen in cycle N is driven onto ddr_* in cycle N+1. Minimum 1 idle cycle between bursts.
- Muxing:
  - In non-IDLE states, ddr_addr, ddr_burst_length, ddr_din and ddr_mask are taken combinationally from the granted slice.
  - req_wait_req[g] = ddr_wait_req. All non-granted requesters see 1.
- READ_CMD:
  - ddr_rd=1.
  - When ddr_wait_req=0, the command is accepted: go to READ_DATA, beat counter=0.
- READ_DATA:
  - Each ddr_valid: req_valid[g]=1 with req_dout=ddr_dout, same cycle (combinational pass-through); counter +1.
  - On the beat where counter = burst-1: req_burst_done[g] pulses on the next cycle, rr pointer := g+1 mod NUM_REQ, state IDLE.
  - New requests are not issued while read data is outstanding.
- WRITE:
  - ddr_wr=req_wr[g].
  - A beat is accepted when req_wr[g]=1 and ddr_wait_req=0; counter +1.
  - Address and burst length are held constant for the whole burst, taken from the granted slice.
  - Last beat accepted: done pulse, rr advance and return to IDLE, as for reads.
  - req_wr[g] deasserting mid-burst stalls the burst; the arbiter does not abandon it.
- Counter is BURST_WIDTH+1 bits. Max burst 2^BURST_WIDTH-1 beats; no wrap.
- req_dout is always ddr_dout; only req_valid is gated.
- Reset mid-burst forces IDLE immediately. Any DDR beats still in flight are discarded and no done pulse is issued.

Optional Feature:
- Macro DDR_ARB_FIXED_PRIORITY_EN.
- Defined: IDLE picks the lowest pending index (0 highest) and the rr pointer is removed.
- Undefined: round-robin as above.
- Grant latency and handshakes are identical either way.

Test Plan:
- Req1 read addr 0x1000, burst 4, wait_req=0, 4 valid beats D0..D3 -> ddr_rd for 1 cycle, addr=0x1000, burst_length=4; req_valid[1] on 4 cycles with D0..D3; done[1] pulses once, 1 cycle after D3.
- Req0 write burst 2 with ddr_wait_req=1 for first 3 cycles -> req_wait_req[0]=1 for those cycles; exactly 2 beats accepted; done[0] pulses.
- Req0,1,2 all reading continuously, burst 1 -> grants 0,1,2,0,1,2. With DDR_ARB_FIXED_PRIORITY_EN defined -> grants 0,0,0.
- Req2 rd and wr both set, burst 1 -> read issued first, then write granted in a later IDLE.
- Req1 burst 0 -> treated as 1 beat; done after a single valid.
- Reset asserted after 2 of 4 read beats, DDR then sends 2 more valid beats -> outputs return to reset values immediately; no req_valid and no done from the stray beats.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter handing the single DDR burst port to NUM_REQ requesters, one whole burst at a time.
// Define DDR_ARB_FIXED_PRIORITY_EN to replace round-robin with fixed priority (index 0 highest).
module ddr_burst_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_rd,
  input  logic [NUM_REQ-1:0]                req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*BURST_WIDTH-1:0]    req_burst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_din,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_mask,
  output logic [NUM_REQ-1:0]                req_wait_req,
  output logic [NUM_REQ-1:0]                req_valid,
  output logic [DATA_WIDTH-1:0]             req_dout,
  output logic [NUM_REQ-1:0]                req_burst_done,
  output logic                              ddr_rd,
  output logic                              ddr_wr,
  output logic [ADDR_WIDTH-1:0]             ddr_addr,
  output logic [BURST_WIDTH-1:0]            ddr_burst_length,
  output logic [DATA_WIDTH/8-1:0]           ddr_mask,
  output logic [DATA_WIDTH-1:0]             ddr_din,
  input  logic [DATA_WIDTH-1:0]             ddr_dout,
  input  logic                              ddr_wait_req,
  input  logic                              ddr_valid
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MW = DATA_WIDTH / 8;
  localparam logic [BURST_WIDTH:0]   CNT_ONE = 1;
  localparam logic [BURST_WIDTH-1:0] BL_ONE  = 1;

  typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, WRITE} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        grant, pick;
  logic                 pick_vld;
  logic [BURST_WIDTH:0] beat_cnt, burst_len;
  logic [NUM_REQ-1:0]   done_q, pending;
  logic                 beat, last_beat;

  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
  logic [BURST_WIDTH-1:0] burst_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]  din_a   [NUM_REQ];
  logic [MW-1:0]          mask_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign burst_a[i] = req_burst[i*BURST_WIDTH +: BURST_WIDTH];
    assign din_a[i]   = req_din[i*DATA_WIDTH +: DATA_WIDTH];
    assign mask_a[i]  = req_mask[i*MW +: MW];
  end

  assign pending = req_rd | req_wr;

`ifdef DDR_ARB_FIXED_PRIORITY_EN
  // Scan downward so the lowest pending index is the last (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (pending[IW'(i)]) begin
        pick     = IW'(i);
        pick_vld = 1'b1;
      end
  end
`else
  logic [IW-1:0] rr;

  // Scan rotated offsets downward so the first pending at/after rr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (pending[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end
`endif

  assign beat      = ((state == READ_DATA) && ddr_valid) ||
                     ((state == WRITE) && req_wr[grant] && !ddr_wait_req);
  assign last_beat = beat && (beat_cnt == burst_len - CNT_ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_vld) state_nxt = req_rd[pick] ? READ_CMD : WRITE;
      READ_CMD:  if (!ddr_wait_req) state_nxt = READ_DATA;
      READ_DATA: if (last_beat) state_nxt = IDLE;
      WRITE:     if (last_beat) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
      done_q    <= '0;
`ifndef DDR_ARB_FIXED_PRIORITY_EN
      rr        <= '0;
`endif
    end else begin
      state  <= state_nxt;
      done_q <= '0;
      if (state == IDLE && pick_vld) begin
        grant     <= pick;
        burst_len <= (burst_a[pick] == '0) ? CNT_ONE : {1'b0, burst_a[pick]};
        beat_cnt  <= '0;
      end else if (state == READ_CMD && !ddr_wait_req) begin
        beat_cnt  <= '0;
      end else if (beat) begin
        beat_cnt  <= beat_cnt + CNT_ONE;
      end
      if (last_beat) begin
        done_q[grant] <= 1'b1;
`ifndef DDR_ARB_FIXED_PRIORITY_EN
        rr <= (grant == IW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
`endif
      end
    end
  end

  // Outside IDLE the granted slice drives the DDR port directly.
  always_comb begin
    ddr_rd           = (state == READ_CMD);
    ddr_wr           = 1'b0;
    ddr_addr         = '0;
    ddr_burst_length = '0;
    ddr_din          = '0;
    ddr_mask         = '0;
    req_wait_req     = '1;
    req_valid        = '0;
    if (state != IDLE) begin
      ddr_addr            = addr_a[grant];
      ddr_burst_length    = (burst_a[grant] == '0) ? BL_ONE : burst_a[grant];
      ddr_din             = din_a[grant];
      ddr_mask            = mask_a[grant];
      req_wait_req[grant] = ddr_wait_req;
    end
    if (state == WRITE)     ddr_wr           = req_wr[grant];
    if (state == READ_DATA) req_valid[grant] = ddr_valid;
  end

  assign req_dout       = ddr_dout;
  assign req_burst_done = done_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: read/write bursts, wait states, arbitration order, burst 0 and mid-burst reset.
module tb_ddr_burst_arbiter;
  localparam int N = 3, AW = 32, DW = 64, BW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_rd, req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*BW-1:0]   req_burst;
  logic [N*DW-1:0]   req_din;
  logic [N*DW/8-1:0] req_mask;
  logic [N-1:0]      req_wait_req, req_valid, req_burst_done;
  logic [DW-1:0]     req_dout;
  logic              ddr_rd, ddr_wr;
  logic [AW-1:0]     ddr_addr;
  logic [BW-1:0]     ddr_burst_length;
  logic [DW/8-1:0]   ddr_mask;
  logic [DW-1:0]     ddr_din, ddr_dout;
  logic              ddr_wait_req, ddr_valid;

  int errors = 0;
  int checks = 0;
  int wr_acc = 0;

  always #5 clock = ~clock;

  ddr_burst_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clock(clock), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_burst(req_burst),
    .req_din(req_din), .req_mask(req_mask), .req_wait_req(req_wait_req),
    .req_valid(req_valid), .req_dout(req_dout), .req_burst_done(req_burst_done),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst_length(ddr_burst_length),
    .ddr_mask(ddr_mask), .ddr_din(ddr_din), .ddr_dout(ddr_dout),
    .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid)
  );

  // Write beats the DDR side actually took.
  always @(posedge clock) if (!reset && ddr_wr && !ddr_wait_req) wr_acc <= wr_acc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int acc0;
    int gexp;
    logic [N-1:0] last_g;
    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_addr = '0; req_burst = '0; req_din = '0; req_mask = '0;
    ddr_dout = '0; ddr_wait_req = 1'b0; ddr_valid = 1'b0;

    // Reset state
    nxt(); settle();
    chk("rst_wait", req_wait_req, 3'b111);
    chk("rst_rd", ddr_rd, 0);
    chk("rst_addr", ddr_addr, 0);
    chk("rst_valid", req_valid, 0);
    chk("rst_done", req_burst_done, 0);
    reset = 1'b0;

    // Read burst 4 by requester 1
    nxt();
    req_rd = 3'b010; req_addr[1*AW +: AW] = 32'h1000; req_burst[1*BW +: BW] = 8'd4;
    settle();
    chk("rd_idle_rd", ddr_rd, 0);
    nxt(); settle();
    chk("rd_cmd", ddr_rd, 1);
    chk("rd_addr", ddr_addr, 32'h1000);
    chk("rd_blen", ddr_burst_length, 4);
    chk("rd_cmd_wait", req_wait_req, 3'b101);
    for (int b = 0; b < 4; b++) begin
      nxt();
      req_rd = '0; ddr_valid = 1'b1; ddr_dout = 64'hD000 + 64'(b);
      settle();
      chk("rd_beat_rd", ddr_rd, 0);
      chk("rd_beat_valid", req_valid, 3'b010);
      chk("rd_beat_dout", req_dout, 64'hD000 + 64'(b));
      chk("rd_beat_nodone", req_burst_done, 0);
    end
    nxt(); ddr_valid = 1'b0; settle();
    chk("rd_done", req_burst_done, 3'b010);
    chk("rd_done_novalid", req_valid, 0);
    nxt(); settle();
    chk("rd_done_once", req_burst_done, 0);

    // Write burst 2 by requester 0 with three stalled cycles
    nxt();
    acc0 = wr_acc;
    req_wr = 3'b001; req_addr[0 +: AW] = 32'h2000; req_burst[0 +: BW] = 8'd2;
    req_din[0 +: DW] = 64'hAAAA; req_mask[0 +: 8] = 8'hFF; ddr_wait_req = 1'b1;
    settle();
    chk("wr_idle_wr", ddr_wr, 0);
    for (int s = 0; s < 3; s++) begin
      nxt(); settle();
      chk("wr_stall_wr", ddr_wr, 1);
      chk("wr_stall_wait", req_wait_req, 3'b111);
      chk("wr_stall_addr", ddr_addr, 32'h2000);
    end
    nxt(); ddr_wait_req = 1'b0; settle();
    chk("wr_b0_wait", req_wait_req, 3'b110);
    chk("wr_b0_din", ddr_din, 64'hAAAA);
    chk("wr_b0_mask", ddr_mask, 8'hFF);
    chk("wr_blen", ddr_burst_length, 2);
    nxt(); req_din[0 +: DW] = 64'hBBBB; settle();
    chk("wr_b1_din", ddr_din, 64'hBBBB);
    chk("wr_b1_addr", ddr_addr, 32'h2000);
    nxt(); req_wr = '0; settle();
    chk("wr_done", req_burst_done, 3'b001);
    chk("wr_after_wr", ddr_wr, 0);
    nxt(); settle();
    chk("wr_beats", 64'(wr_acc - acc0), 2);

    // Arbitration order with all three reading, burst 1
    reset = 1'b1; nxt(); reset = 1'b0;
    req_burst = {8'd1, 8'd1, 8'd1};
    for (int b = 0; b < 6; b++) begin
`ifdef DDR_ARB_FIXED_PRIORITY_EN
      gexp = 0;
`else
      gexp = b % 3;
`endif
      nxt(); req_rd = 3'b111; ddr_valid = 1'b1; ddr_dout = 64'(b); settle();
      chk("arb_idle", ddr_rd, 0);
      nxt(); settle();
      chk("arb_cmd", ddr_rd, 1);
      chk("arb_grant_wait", req_wait_req, 64'(3'b111 & ~(3'b001 << gexp)));
      nxt(); settle();
      chk("arb_grant_valid", req_valid, 64'(3'b001 << gexp));
    end
`ifdef DDR_ARB_FIXED_PRIORITY_EN
    last_g = 3'b001;
`else
    last_g = 3'b100;
`endif
    nxt(); req_rd = '0; ddr_valid = 1'b0; settle();
    chk("arb_last_done", req_burst_done, last_g);

    // Requester 2 with rd and wr together: read first, write later
    nxt();
    req_rd = 3'b100; req_wr = 3'b100; req_burst[2*BW +: BW] = 8'd1;
    req_addr[2*AW +: AW] = 32'h3000; req_din[2*DW +: DW] = 64'h5555;
    settle();
    chk("rw_idle", ddr_rd, 0);
    nxt(); settle();
    chk("rw_rd_first", ddr_rd, 1);
    chk("rw_no_wr", ddr_wr, 0);
    nxt(); req_rd = '0; ddr_valid = 1'b1; settle();
    chk("rw_rd_valid", req_valid, 3'b100);
    nxt(); ddr_valid = 1'b0; settle();
    chk("rw_rd_done", req_burst_done, 3'b100);
    chk("rw_idle_wr", ddr_wr, 0);
    nxt(); settle();
    chk("rw_wr", ddr_wr, 1);
    chk("rw_wr_wait", req_wait_req, 3'b011);
    chk("rw_wr_din", ddr_din, 64'h5555);
    nxt(); req_wr = '0; settle();
    chk("rw_wr_done", req_burst_done, 3'b100);

    // Burst length 0 behaves as 1 beat
    nxt(); req_rd = 3'b010; req_burst[1*BW +: BW] = 8'd0; settle();
    nxt(); settle();
    chk("b0_cmd", ddr_rd, 1);
    chk("b0_blen", ddr_burst_length, 1);
    nxt(); req_rd = '0; ddr_valid = 1'b1; ddr_dout = 64'h77; settle();
    chk("b0_valid", req_valid, 3'b010);
    nxt(); ddr_valid = 1'b0; settle();
    chk("b0_done", req_burst_done, 3'b010);
    nxt(); settle();
    chk("b0_done_once", req_burst_done, 0);

    // Reset after 2 of 4 beats, stray beats afterwards
    nxt(); req_rd = 3'b010; req_burst[1*BW +: BW] = 8'd4; settle();
    nxt(); settle();
    chk("mr_cmd", ddr_rd, 1);
    for (int b = 0; b < 2; b++) begin
      nxt(); req_rd = '0; ddr_valid = 1'b1; ddr_dout = 64'hE0 + 64'(b); settle();
      chk("mr_beat", req_valid, 3'b010);
    end
    nxt(); reset = 1'b1; ddr_dout = 64'hE2; settle();
    chk("mr_rst_valid", req_valid, 0);
    chk("mr_rst_wait", req_wait_req, 3'b111);
    chk("mr_rst_addr", ddr_addr, 0);
    chk("mr_rst_blen", ddr_burst_length, 0);
    chk("mr_rst_rd", ddr_rd, 0);
    nxt(); reset = 1'b0; ddr_dout = 64'hE3; settle();
    chk("mr_stray_valid", req_valid, 0);
    chk("mr_stray_done", req_burst_done, 0);
    nxt(); ddr_valid = 1'b0; settle();
    chk("mr_no_done", req_burst_done, 0);
    chk("mr_idle_rd", ddr_rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
